// File: rtl/lcd_pkg.sv
// Shared LCD timing defaults, colour constants and RGB helpers.
// Used by the scan driver and the sprite pixel generators.
package lcd_pkg;

    localparam int COORD_W = 12;
    localparam int RGB_W   = 24;

    localparam int H_ACTIVE_DEF    = 800;
    localparam int H_FP_DEF        = 40;
    localparam int H_SYNC_DEF      = 128;
    localparam int H_BP_DEF        = 88;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_FP_DEF        = 1;
    localparam int V_SYNC_DEF      = 3;
    localparam int V_BP_DEF        = 21;
    localparam int PIX_LATENCY_DEF = 3;

    localparam logic [RGB_W-1:0] BG_COLOR_DEF = 24'h000000;
    localparam logic [RGB_W-1:0] BORDER_COLOR = 24'hFFFFFF;

    // Replicate the MSBs into the low bits so full-scale 565 maps to 0xFF.
    function automatic logic [RGB_W-1:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register whose stages reset to a given value.
// Keeps panel controls aligned with the sprite pipeline latency.
module sig_delay
    import lcd_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("sig_delay: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= RESET_VAL;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/lcd_scan_driver.sv
// Raster counter and panel pin driver; aligns sprite responses with
// DE/HSYNC/VSYNC and substitutes the background colour.
module lcd_scan_driver
    import lcd_pkg::*;
#(
    parameter int               H_ACTIVE    = H_ACTIVE_DEF,
    parameter int               H_FP        = H_FP_DEF,
    parameter int               H_SYNC      = H_SYNC_DEF,
    parameter int               H_BP        = H_BP_DEF,
    parameter int               V_ACTIVE    = V_ACTIVE_DEF,
    parameter int               V_FP        = V_FP_DEF,
    parameter int               V_SYNC      = V_SYNC_DEF,
    parameter int               V_BP        = V_BP_DEF,
    parameter int               PIX_LATENCY = PIX_LATENCY_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR    = BG_COLOR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scan_en,
    output logic [COORD_W-1:0] lcd_xpos,
    output logic [COORD_W-1:0] lcd_ypos,
    input  logic [RGB_W-1:0]   sprite_pixel,
    input  logic               sprite_valid,
    output logic               lcd_de,
    output logic               lcd_hsync,
    output logic               lcd_vsync,
    output logic [RGB_W-1:0]   lcd_data,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_timing
        $error("lcd_scan_driver: H_TOTAL and V_TOTAL must be <= 4096");
    end
    if (PIX_LATENCY < 1) begin : g_bad_latency
        $error("lcd_scan_driver: PIX_LATENCY must be at least 1");
    end

    // One extra bit so a sync end equal to 4096 still compares correctly.
    localparam logic [12:0] H_ACT = 13'(H_ACTIVE);
    localparam logic [12:0] HS_LO = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_HI = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT = 13'(V_ACTIVE);
    localparam logic [12:0] VS_LO = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_HI = 13'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_TOTAL - 1);

    logic [12:0] x_ext;
    logic [12:0] y_ext;
    logic        de_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  ctl_d;
    logic        de_d;
    logic        hs_d;
    logic        vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_xpos <= '0;
            lcd_ypos <= '0;
        end else if (!scan_en) begin
            lcd_xpos <= '0;
            lcd_ypos <= '0;
        end else if (lcd_xpos == X_LAST) begin
            lcd_xpos <= '0;
            lcd_ypos <= (lcd_ypos == Y_LAST) ? '0 : lcd_ypos + 1'b1;
        end else begin
            lcd_xpos <= lcd_xpos + 1'b1;
        end
    end

    assign x_ext = {1'b0, lcd_xpos};
    assign y_ext = {1'b0, lcd_ypos};

    always_comb begin
        de_raw = 1'b0;
        hs_raw = 1'b1;
        vs_raw = 1'b1;
        if (scan_en) begin
            de_raw = (x_ext < H_ACT) && (y_ext < V_ACT);
            hs_raw = !((x_ext >= HS_LO) && (x_ext < HS_HI));
            vs_raw = !((y_ext >= VS_LO) && (y_ext < VS_HI));
        end
    end

    sig_delay #(
        .WIDTH     (3),
        .DEPTH     (PIX_LATENCY),
        .RESET_VAL (3'b011)
    ) u_ctl_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({de_raw, hs_raw, vs_raw}),
        .dout  (ctl_d)
    );

    assign de_d = ctl_d[2];
    assign hs_d = ctl_d[1];
    assign vs_d = ctl_d[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_de      <= 1'b0;
            lcd_hsync   <= 1'b1;
            lcd_vsync   <= 1'b1;
            lcd_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            lcd_de      <= de_d;
            lcd_hsync   <= hs_d;
            lcd_vsync   <= vs_d;
            if (!de_d) begin
                lcd_data <= '0;
            end else if (sprite_valid) begin
                lcd_data <= sprite_pixel;
            end else begin
                lcd_data <= BG_COLOR;
            end
            frame_start <= scan_en && (lcd_xpos == '0) && (lcd_ypos == '0);
        end
    end

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Randomized bench for lcd_scan_driver on a 14x7 raster, checked
// against a frame-position reference model.
module tb_lcd_scan_driver;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [23:0] HIT_PIX = 24'hABCDEF;
    localparam logic [23:0] BG1     = 24'h112233;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        scan_en = 1'b1;
    logic [23:0] sprite_pixel;
    logic        sprite_valid;

    logic [11:0] lcd_xpos, lcd_ypos, lcd_xpos1, lcd_ypos1;
    logic        lcd_de, lcd_hsync, lcd_vsync, frame_start;
    logic        lcd_de1, lcd_hsync1, lcd_vsync1, frame_start1;
    logic [23:0] lcd_data, lcd_data1;

    lcd_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_LATENCY(3), .BG_COLOR(24'h000000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
        .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
        .sprite_pixel(sprite_pixel), .sprite_valid(sprite_valid),
        .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
        .lcd_data(lcd_data), .frame_start(frame_start)
    );

    lcd_scan_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_LATENCY(3), .BG_COLOR(BG1)
    ) dut_bg (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
        .lcd_xpos(lcd_xpos1), .lcd_ypos(lcd_ypos1),
        .sprite_pixel(sprite_pixel), .sprite_valid(sprite_valid),
        .lcd_de(lcd_de1), .lcd_hsync(lcd_hsync1), .lcd_vsync(lcd_vsync1),
        .lcd_data(lcd_data1), .frame_start(frame_start1)
    );

    always #5 clk = ~clk;

    // 3-clock sprite source: opaque only at (5,2), or forced opaque.
    logic [23:0] sp0 = '0, sp1 = '0, sp2 = '0;
    logic        force_mode = 1'b0;
    logic [23:0] rnd_pix = '0;

    always @(posedge clk) begin
        sp0 <= {lcd_xpos, lcd_ypos};
        sp1 <= sp0;
        sp2 <= sp1;
    end

    assign sprite_valid = force_mode | (sp2 == {12'd5, 12'd2});
    assign sprite_pixel = force_mode ? rnd_pix : HIT_PIX;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: linear position within the frame, plus a history
    // of what each past cycle presented and received.
    typedef struct packed {
        logic        de;
        logic        hsl;
        logic        vsl;
        logic        hit;
        logic        fs;
        logic        frc;
        logic [23:0] pix;
    } ent_t;

    ent_t        hist[$];
    int          pos;
    int          ex, ey;
    logic        ede, ehs, evs, efs;
    logic [23:0] edata, edata1;
    logic        chk_on = 1'b0;

    task automatic model_reset();
        hist = {};
        repeat (4) hist.push_back('0);
        pos = 0; ex = 0; ey = 0;
        ede = 1'b0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
        edata = '0; edata1 = '0;
    endtask

    task automatic model_step();
        ent_t e;
        int   x, y;
        x = pos % HT;
        y = pos / HT;
        e.de  = scan_en && x < HA && y < VA;
        e.hsl = scan_en && x >= HA + HF && x < HA + HF + HS;
        e.vsl = scan_en && y >= VA + VF && y < VA + VF + VS;
        e.hit = scan_en && x == 5 && y == 2;
        e.fs  = scan_en && pos == 0;
        e.frc = force_mode;
        e.pix = sprite_pixel;
        hist.push_front(e);
        if (hist.size() > 4) void'(hist.pop_back());
        ede = hist[3].de;
        ehs = !hist[3].hsl;
        evs = !hist[3].vsl;
        efs = hist[0].fs;
        if (!hist[3].de) begin
            edata = '0; edata1 = '0;
        end else if (hist[0].frc) begin
            edata = hist[0].pix; edata1 = hist[0].pix;
        end else if (hist[3].hit) begin
            edata = HIT_PIX; edata1 = HIT_PIX;
        end else begin
            edata = 24'h000000; edata1 = BG1;
        end
        pos = scan_en ? (pos + 1) % FT : 0;
        ex = pos % HT;
        ey = pos / HT;
    endtask

    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) begin
        if (chk_on) begin
            chk("xpos", 32'(lcd_xpos), 32'(ex));
            chk("ypos", 32'(lcd_ypos), 32'(ey));
            chk("de", 32'(lcd_de), 32'(ede));
            chk("hsync", 32'(lcd_hsync), 32'(ehs));
            chk("vsync", 32'(lcd_vsync), 32'(evs));
            chk("data", 32'(lcd_data), 32'(edata));
            chk("frame_start", 32'(frame_start), 32'(efs));
            chk("data_bg", 32'(lcd_data1), 32'(edata1));
            chk("ctl_bg", {4'h0, lcd_xpos1, lcd_ypos1, lcd_de1, lcd_hsync1,
                           lcd_vsync1, frame_start1},
                {4'h0, 12'(ex), 12'(ey), ede, ehs, evs, efs});
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(lcd_xpos), 32'd0);
        chk({tag, "_y"}, 32'(lcd_ypos), 32'd0);
        chk({tag, "_de"}, 32'(lcd_de), 32'd0);
        chk({tag, "_hs"}, 32'(lcd_hsync), 32'd1);
        chk({tag, "_vs"}, 32'(lcd_vsync), 32'd1);
        chk({tag, "_data"}, 32'(lcd_data), 32'd0);
        chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    task automatic wait_xy(input int x, input int y);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ex == x && ey == y) && k < 300);
        chk("wait_xy", 32'(k < 300), 32'd1);
    endtask

    task automatic frame_stats(input string tag);
        int k, nde, nfs, nhit, nhs, nvs;
        k = 0; nde = 0; nfs = 0; nhit = 0; nhs = 0; nvs = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 300);
        chk({tag, "_fs_seen"}, 32'(k < 300), 32'd1);
        repeat (FT) begin
            @(negedge clk);
            nde  += int'(lcd_de);
            nfs  += int'(frame_start);
            nhit += int'(lcd_de && lcd_data == HIT_PIX);
            nhs  += int'(!lcd_hsync);
            nvs  += int'(!lcd_vsync);
        end
        chk({tag, "_de_cnt"}, 32'(nde), 32'(HA * VA));
        chk({tag, "_fs_cnt"}, 32'(nfs), 32'd1);
        chk({tag, "_hit_cnt"}, 32'(nhit), 32'd1);
        chk({tag, "_hs_low"}, 32'(nhs), 32'(HS * VT));
        chk({tag, "_vs_low"}, 32'(nvs), 32'(VS * HT));
    endtask

    initial begin
        int nfs;
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("fs_first", 32'(frame_start), 32'd1);

        frame_stats("frame_a");

        force_mode = 1'b1;
        repeat (2 * FT) begin
            @(posedge clk);
            #1 rnd_pix = 24'($urandom);
        end
        @(posedge clk);
        #1 force_mode = 1'b0;

        wait_xy(6, 2);
        scan_en = 1'b0;
        nfs = 0;
        repeat (12) begin
            @(negedge clk);
            nfs += int'(frame_start);
        end
        chk("fs_while_off", 32'(nfs), 32'd0);
        chk("off_de", 32'(lcd_de), 32'd0);
        chk("off_hs_vs", {30'd0, lcd_hsync, lcd_vsync}, 32'd3);
        scan_en = 1'b1;
        @(posedge clk);
        #1 chk("fs_reassert", 32'(frame_start), 32'd1);
        frame_stats("frame_b");

        repeat (700) begin
            @(posedge clk);
            #1;
            scan_en = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 49) == 0) force_mode = !force_mode;
            rnd_pix = 24'($urandom);
        end
        scan_en = 1'b1;
        force_mode = 1'b0;

        wait_xy(9, 3);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("fs_after_rst", 32'(frame_start), 32'd1);
        frame_stats("frame_c");

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
